calc_rx_deser: RTL and testbench

- Downstream consumer of the binary calculator's serial result port (DataOut / ClkTx / DoutValid).
- Oversamples the divided transmit clock in the system Clk domain and shifts in one result frame.
- Splits the frame into operand, selector and result fields.
- Presents each frame on a valid/ready parallel interface to the display/logging stage, with overflow and frame-error reporting.

---
 rtl/calc_rx_deser.sv | 230 +++++++++++++++++++++++
 tb/tb_calc_rx_deser.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_rx_deser.sv
// ============================================================================
// Module      : calc_rx_deser
// Description : Receives one serial result frame from the binary calculator
//               (DataOut / ClkTx / DoutValid). The transmit clock is
//               oversampled in the Clk domain. The frame is split into
//               operand A, operand B, selector and result fields and is
//               offered on a valid/ready parallel port. Frame errors and
//               overflow are reported on dedicated outputs.
//               Optional statistics counters are enabled by defining the
//               macro CALC_RX_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module calc_rx_deser #(
    parameter int DATA_W      = 8,
    parameter int SEL_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              DoutValid,
    input  logic              DataOut,
    input  logic              ClkTx,
    input  logic              RxReady,
    output logic [DATA_W-1:0] RxA,
    output logic [DATA_W-1:0] RxB,
    output logic [SEL_W-1:0]  RxSel,
    output logic [DATA_W-1:0] RxResult,
    output logic              RxValid,
    output logic              RxBusy,
    output logic              RxFrameErr,
    output logic              RxOverflow
`ifdef CALC_RX_STATS_EN
    ,
    output logic [15:0]       RxFrameCnt,
    output logic [7:0]        RxErrCnt
`endif
);

    localparam int FRAME_W = 3*DATA_W + SEL_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SHIFT    = 2'd1,
        S_LOAD     = 2'd2,
        S_WAIT_LOW = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_dataSync;
    logic [SYNC_STAGES-1:0] r_validSync;
    logic [SYNC_STAGES-1:0] r_clkSync;
    logic                   r_clkPrev;
    logic [FRAME_W-1:0]     r_shift;
    logic [CNT_W-1:0]       r_bitCnt;
    logic                   r_longErr;
    state_t                 r_state;
    state_t                 w_nextState;

    logic [DATA_W-1:0]      r_rxA;
    logic [DATA_W-1:0]      r_rxB;
    logic [SEL_W-1:0]       r_rxSel;
    logic [DATA_W-1:0]      r_rxResult;
    logic                   r_valid;
    logic                   r_frameErr;
    logic                   r_overflow;

    logic w_dataS;
    logic w_validS;
    logic w_sample;
    logic w_shiftEn;
    logic w_errPulse;
    logic w_load;
    logic w_loadOk;
    logic w_accept;

    // All three serial inputs share one sync depth so they stay bit-aligned
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_dataSync  <= '0;
            r_validSync <= '0;
            r_clkSync   <= '0;
            r_clkPrev   <= 1'b0;
        end else begin
            r_dataSync  <= {r_dataSync[SYNC_STAGES-2:0],  DataOut};
            r_validSync <= {r_validSync[SYNC_STAGES-2:0], DoutValid};
            r_clkSync   <= {r_clkSync[SYNC_STAGES-2:0],   ClkTx};
            r_clkPrev   <= r_clkSync[SYNC_STAGES-1];
        end
    end

    assign w_dataS  = r_dataSync[SYNC_STAGES-1];
    assign w_validS = r_validSync[SYNC_STAGES-1];
    assign w_sample = r_clkSync[SYNC_STAGES-1] & ~r_clkPrev;

    // State register
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode and per-cycle control strobes
    always_comb begin
        w_nextState = r_state;
        w_shiftEn   = 1'b0;
        w_errPulse  = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_sample && w_validS) begin
                    w_shiftEn   = 1'b1;
                    w_nextState = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (!w_validS) begin
                    w_errPulse  = 1'b1;
                    w_nextState = S_IDLE;
                end else if (w_sample) begin
                    w_shiftEn = 1'b1;
                    if (r_bitCnt == CNT_W'(FRAME_W - 1)) begin
                        w_nextState = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                w_load      = 1'b1;
                w_nextState = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (!w_validS) begin
                    w_nextState = S_IDLE;
                end else if (w_sample && !r_longErr) begin
                    w_errPulse = 1'b1;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Shift register, bit counter and the one-shot over-long error flag
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_shift   <= '0;
            r_bitCnt  <= '0;
            r_longErr <= 1'b0;
        end else begin
            if (w_shiftEn) begin
                r_shift  <= {r_shift[FRAME_W-2:0], w_dataS};
                r_bitCnt <= (r_state == S_IDLE) ? CNT_W'(1) : r_bitCnt + CNT_W'(1);
            end
            if (w_load) begin
                r_longErr <= 1'b0;
            end else if (w_errPulse && (r_state == S_WAIT_LOW)) begin
                r_longErr <= 1'b1;
            end
        end
    end

    // A frame may load when the slot is empty or is being emptied this cycle
    assign w_accept = r_valid & RxReady;
    assign w_loadOk = w_load & (~r_valid | RxReady);

    // Output slot, handshake, error pulse and sticky overflow
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_rxA      <= '0;
            r_rxB      <= '0;
            r_rxSel    <= '0;
            r_rxResult <= '0;
            r_valid    <= 1'b0;
            r_frameErr <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_frameErr <= w_errPulse;
            if (w_loadOk) begin
                r_rxA      <= r_shift[3*DATA_W+SEL_W-1 -: DATA_W];
                r_rxB      <= r_shift[2*DATA_W+SEL_W-1 -: DATA_W];
                r_rxSel    <= r_shift[DATA_W+SEL_W-1 -: SEL_W];
                r_rxResult <= r_shift[DATA_W-1:0];
                r_valid    <= 1'b1;
            end else if (w_accept) begin
                r_valid    <= 1'b0;
            end
            if (w_load && !w_loadOk) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign RxA        = r_rxA;
    assign RxB        = r_rxB;
    assign RxSel      = r_rxSel;
    assign RxResult   = r_rxResult;
    assign RxValid    = r_valid;
    assign RxBusy     = (r_state != S_IDLE);
    assign RxFrameErr = r_frameErr;
    assign RxOverflow = r_overflow;

`ifdef CALC_RX_STATS_EN
    logic [15:0] r_frameCnt;
    logic [7:0]  r_errCnt;

    // Saturating counters of loaded frames (kept or dropped) and error pulses
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_frameCnt <= '0;
            r_errCnt   <= '0;
        end else begin
            if (w_load && (r_frameCnt != 16'hFFFF)) begin
                r_frameCnt <= r_frameCnt + 16'd1;
            end
            if (w_errPulse && (r_errCnt != 8'hFF)) begin
                r_errCnt <= r_errCnt + 8'd1;
            end
        end
    end

    assign RxFrameCnt = r_frameCnt;
    assign RxErrCnt   = r_errCnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_calc_rx_deser.sv
// ============================================================================
// Module      : tb_calc_rx_deser
// Description : Self-checking bench for calc_rx_deser. It uses a vector table,
//               randomized frames checked against a frame-level model, and
//               hand sequences for backpressure, accept-during-load and
//               mid-frame reset. Statistics checks apply when
//               CALC_RX_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_calc_rx_deser;

    localparam int DW   = 8;
    localparam int SW   = 4;
    localparam int SYNC = 2;
    localparam int FW   = 3*DW + SW;

    typedef logic [FW-1:0] word_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
        logic [7:0] res;
        int         nbits;
        int         expDel;
        int         expErr;
    } vec_t;

    logic          Clk = 1'b0;
    logic          ResetN = 1'b0;
    logic          DoutValid = 1'b0;
    logic          DataOut = 1'b0;
    logic          ClkTx = 1'b0;
    logic          RxReady = 1'b0;
    logic [DW-1:0] RxA, RxB, RxResult;
    logic [SW-1:0] RxSel;
    logic          RxValid, RxBusy, RxFrameErr, RxOverflow;
`ifdef CALC_RX_STATS_EN
    logic [15:0]   RxFrameCnt;
    logic [7:0]    RxErrCnt;
`endif

    calc_rx_deser #(.DATA_W(DW), .SEL_W(SW), .SYNC_STAGES(SYNC)) dut (
        .Clk        (Clk),
        .ResetN     (ResetN),
        .DoutValid  (DoutValid),
        .DataOut    (DataOut),
        .ClkTx      (ClkTx),
        .RxReady    (RxReady),
        .RxA        (RxA),
        .RxB        (RxB),
        .RxSel      (RxSel),
        .RxResult   (RxResult),
        .RxValid    (RxValid),
        .RxBusy     (RxBusy),
        .RxFrameErr (RxFrameErr),
        .RxOverflow (RxOverflow)
`ifdef CALC_RX_STATS_EN
        ,
        .RxFrameCnt (RxFrameCnt),
        .RxErrCnt   (RxErrCnt)
`endif
    );

    always #5 Clk = ~Clk;

    int    checks = 0;
    int    errors = 0;
    word_t capQ[$];
    word_t expQ[$];
    int    validCycles = 0;
    int    errPulses = 0;
    int    q0, v0, e0, modelErr, nb, lo, hi, pick;
    word_t wrd, f1, f2;
    vec_t  tbl[6];

    // Observe the parallel port mid-cycle: accepted words and error pulses
    always @(negedge Clk) begin
        if (ResetN) begin
            if (RxValid) validCycles++;
            if (RxValid && RxReady) capQ.push_back({RxA, RxB, RxSel, RxResult});
            if (RxFrameErr) errPulses++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic do_reset();
        ResetN    = 1'b0;
        DoutValid = 1'b0;
        ClkTx     = 1'b0;
        DataOut   = 1'b0;
        RxReady   = 1'b0;
        repeat (3) tick();
        ResetN = 1'b1;
        repeat (2) tick();
        capQ.delete();
        validCycles = 0;
        errPulses   = 0;
    endtask

    // Transmit nbits of a frame MSB first; optional ready pulse in the LOAD
    // cycle of the last bit, optional reset assertion at bit abortAt.
    task automatic send_frame(input word_t bits, input int nbits, input int lo_c,
                              input int hi_c, input bit pulseRdy, input int abortAt);
        DoutValid = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            if (i == abortAt) begin
                ResetN    = 1'b0;
                DoutValid = 1'b0;
                ClkTx     = 1'b0;
                return;
            end
            DataOut = (i < FW) ? bits[FW-1-i] : 1'($urandom);
            ClkTx   = 1'b0;
            repeat (lo_c) tick();
            ClkTx = 1'b1;
            for (int c = 0; c < hi_c; c++) begin
                tick();
                if (pulseRdy && (i == nbits - 1)) begin
                    if (c == SYNC) RxReady = 1'b1;
                    else if (c == SYNC + 1) RxReady = 1'b0;
                end
            end
        end
        ClkTx = 1'b0;
        repeat (SYNC + 3) tick();
        DoutValid = 1'b0;
        repeat (SYNC + 6) tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // ---------------- reset state ----------------
        repeat (2) tick();
        check("rst_valid", RxValid, 0);
        check("rst_busy", RxBusy, 0);
        check("rst_fields", {RxA, RxB, RxSel, RxResult}, 0);
        ResetN = 1'b1;
        repeat (2) tick();
        check("rst_err_ovf", {RxFrameErr, RxOverflow}, 0);

        // ---------------- table-driven vectors ----------------
        tbl[0] = '{8'h05, 8'h01, 4'h5, 8'h06, FW,     1, 0};
        tbl[1] = '{8'hA5, 8'h3C, 4'h9, 8'h77, 12,     0, 1};
        tbl[2] = '{8'h03, 8'h08, 4'h3, 8'h18, FW,     1, 0};
        tbl[3] = '{8'hFF, 8'h00, 4'hF, 8'h80, FW + 3, 1, 1};
        tbl[4] = '{8'h12, 8'h34, 4'h6, 8'h56, FW - 1, 0, 1};
        tbl[5] = '{8'h81, 8'h7E, 4'hA, 8'hC3, FW + 1, 1, 1};
        RxReady = 1'b1;
        for (int t = 0; t < 6; t++) begin
            q0  = capQ.size();
            v0  = validCycles;
            e0  = errPulses;
            wrd = {tbl[t].a, tbl[t].b, tbl[t].sel, tbl[t].res};
            send_frame(wrd, tbl[t].nbits, 4, 4, 1'b0, -1);
            check($sformatf("tbl%0d_errpulses", t), errPulses - e0, tbl[t].expErr);
            check($sformatf("tbl%0d_delivered", t), capQ.size() - q0, tbl[t].expDel);
            check($sformatf("tbl%0d_validcycles", t), validCycles - v0, tbl[t].expDel);
            if (capQ.size() > q0) check($sformatf("tbl%0d_word", t), capQ[$], wrd);
            check($sformatf("tbl%0d_overflow", t), RxOverflow, 0);
        end
`ifdef CALC_RX_STATS_EN
        check("tbl_framecnt", RxFrameCnt, 4);
        check("tbl_errcnt", RxErrCnt, 4);
`endif

        // ---------------- randomized frames vs frame-level model ----------------
        do_reset();
        RxReady  = 1'b1;
        modelErr = 0;
        expQ.delete();
        for (int f = 0; f < 24; f++) begin
            wrd  = word_t'($urandom);
            pick = $urandom_range(0, 3);
            if (pick <= 1) nb = FW;
            else if (pick == 2) nb = $urandom_range(1, FW - 1);
            else nb = $urandom_range(FW + 1, FW + 4);
            lo = $urandom_range(SYNC + 1, 6);
            hi = $urandom_range(SYNC + 1, 6);
            if (nb >= FW) expQ.push_back(wrd);
            if (nb != FW) modelErr++;
            send_frame(wrd, nb, lo, hi, 1'b0, -1);
            check($sformatf("rnd%0d_errpulses", f), errPulses, modelErr);
            check($sformatf("rnd%0d_count", f), capQ.size(), expQ.size());
            while ((capQ.size() > 0) && (expQ.size() > 0))
                check($sformatf("rnd%0d_word", f), capQ.pop_front(), expQ.pop_front());
        end
        check("rnd_overflow", RxOverflow, 0);

        // ---------------- accept coinciding with LOAD ----------------
        do_reset();
        f1 = {8'h11, 8'h22, 4'h3, 8'h33};
        f2 = {8'h44, 8'h55, 4'h6, 8'h99};
        send_frame(f1, FW, 4, 4, 1'b0, -1);
        check("sim_first_valid", RxValid, 1);
        send_frame(f2, FW, 4, 4, 1'b1, -1);
        check("sim_valid", RxValid, 1);
        check("sim_word", {RxA, RxB, RxSel, RxResult}, f2);
        check("sim_overflow", RxOverflow, 0);
        check("sim_accepted_cnt", capQ.size(), 1);
        if (capQ.size() > 0) check("sim_accepted_word", capQ[0], f1);

        // ---------------- backpressure / overflow ----------------
        do_reset();
        f1 = {8'h01, 8'h10, 4'h1, 8'h11};
        f2 = {8'h02, 8'h20, 4'h2, 8'h22};
        send_frame(f1, FW, 4, 4, 1'b0, -1);
        send_frame(f2, FW, 4, 4, 1'b0, -1);
        check("bp_valid", RxValid, 1);
        check("bp_word", {RxA, RxB, RxSel, RxResult}, f1);
        check("bp_overflow", RxOverflow, 1);
        RxReady = 1'b1;
        tick();
        check("bp_valid_cleared", RxValid, 0);
        check("bp_overflow_sticky", RxOverflow, 1);
        check("bp_accepted_cnt", capQ.size(), 1);
        if (capQ.size() > 0) check("bp_accepted_word", capQ[0], f1);

        // ---------------- reset mid-frame ----------------
        do_reset();
        f1 = {8'hC3, 8'h5A, 4'hE, 8'h3C};
        send_frame(f1, FW, 4, 4, 1'b0, -1);
        check("mrst_pre_valid", RxValid, 1);
        send_frame({8'h77, 8'h66, 4'h5, 8'h44}, FW, 4, 4, 1'b0, 10);
        #1;
        check("mrst_valid", RxValid, 0);
        check("mrst_busy", RxBusy, 0);
        check("mrst_fields", {RxA, RxB, RxSel, RxResult}, 0);
        check("mrst_err_ovf", {RxFrameErr, RxOverflow}, 0);
        repeat (3) tick();
        ResetN = 1'b1;
        repeat (2) tick();
        RxReady = 1'b1;
        wrd = {8'h09, 8'h07, 4'h2, 8'h3F};
        send_frame(wrd, FW, 4, 4, 1'b0, -1);
        check("mrst_errpulses", errPulses, 0);
        check("mrst_delivered", capQ.size(), 1);
        if (capQ.size() > 0) check("mrst_word", capQ[$], wrd);
`ifdef CALC_RX_STATS_EN
        check("mrst_framecnt", RxFrameCnt, 1);
        check("mrst_errcnt", RxErrCnt, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
